wb_bram32_ctrl: RTL

- Wishbone classic slave front-end that sits directly upstream of the 32-bit single-port block RAM and drives its di/do/we/a port.
- Converts bus cycles from the LM32 instruction/data buses or the CSR bridge into BRAM accesses.
- Inserts the one-cycle read latency and performs read-modify-write for byte-lane writes, because the RAM supports only full-word write enable.

---
 rtl/wb_bram32_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/wb_bram32_ctrl.sv
// Wishbone classic slave in front of a 32-bit single-port block RAM.
// Adds the RAM's one-cycle read latency and turns byte-lane writes into a
// read-modify-write, since the RAM only has a full-word write enable.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request; full-word / empty writes finish here
// RD     | RAM read data arriving, capture into wb_dat_o
// RMW_RD | old word arriving, merge selected lanes of wb_dat_i into it
// RMW_WR | write the merged word back
// ACK    | ack pulse cycle; forces a dead cycle before the next access
module wb_bram32_ctrl #(
    parameter int adr_width = 11
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic [15:0] mem_a,
    output logic [31:0] mem_di,
    input  logic [31:0] mem_do,
    output logic        mem_we
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        ACK    = 3'd4
    } state_t;

    localparam logic [31:0] ADR_MASK = (32'd1 << adr_width) - 32'd4;

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] merge_q, merge_d;
    logic        we_raw;
    logic        req;

    // Upper address bits only alias onto the window and are never decoded.
    logic        unused_adr;
    assign unused_adr = ^wb_adr_i[31:16];

    assign req      = wb_cyc_i & wb_stb_i;
    assign mem_a    = 16'(wb_adr_i & ADR_MASK);
    assign mem_we   = we_raw & ~sys_rst;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

    // State and data registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            dat_q   <= 32'h0;
            merge_q <= 32'h0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            merge_q <= merge_d;
        end
    end

    // Next-state, RAM strobes and merge data.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        merge_d = merge_q;
        we_raw  = 1'b0;
        mem_di  = wb_dat_i;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!wb_we_i) begin
                        state_d = RD;
                    end else if (wb_sel_i == 4'hF) begin
                        we_raw  = 1'b1;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else if (wb_sel_i == 4'h0) begin
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            RD: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    dat_d   = mem_do;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            RMW_RD: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        merge_d[8*i +: 8] = wb_sel_i[i] ? wb_dat_i[8*i +: 8]
                                                        : mem_do[8*i +: 8];
                    end
                    state_d = RMW_WR;
                end
            end
            RMW_WR: begin
                mem_di = merge_q;
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    we_raw  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
